// File: rtl/uesprit_pkg.sv
// Shared constants and helpers for the UESPRIT correlation accumulator.
package uesprit_pkg;

    // din_valid of a last-frame sample to its dout_valid, in clock cycles
    localparam int unsigned LATENCY = 6;

    // Container width used by the saturation helper
    localparam int unsigned SAT_W = 64;

    // Number of correlation terms per bin: r11, r22, r12_re, r12_im
    localparam int NC = 4;

    // Width of |x|^2 and of the cross-product sums
    function automatic int unsigned calc_pw(input int unsigned din_width);
        return 2 * din_width + 1;
    endfunction

    // Accumulator width: enough headroom for 2^acc_len_width-1 frames
    function automatic int unsigned calc_acc_w(input int unsigned din_width,
                                               input int unsigned acc_len_width);
        return calc_pw(din_width) + acc_len_width;
    endfunction

    // Clamp a signed value to the range of a signed word of the given width
    function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                    input int unsigned width);
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/uesprit_corr_mac.sv
// Three-stage correlation MAC: input register, products, sums.
module uesprit_corr_mac #(
    parameter int unsigned DIN_WIDTH = 18,
    parameter int unsigned PW        = 37
) (
    input  logic                        clk,
    input  logic signed [DIN_WIDTH-1:0] din1_re,
    input  logic signed [DIN_WIDTH-1:0] din1_im,
    input  logic signed [DIN_WIDTH-1:0] din2_re,
    input  logic signed [DIN_WIDTH-1:0] din2_im,
    output logic signed [PW-1:0]        r11,
    output logic signed [PW-1:0]        r22,
    output logic signed [PW-1:0]        r12_re,
    output logic signed [PW-1:0]        r12_im
);

    localparam int unsigned MW = 2 * DIN_WIDTH;

    logic signed [DIN_WIDTH-1:0] x1_re_q, x1_im_q, x2_re_q, x2_im_q;
    logic signed [MW-1:0] p1rr_q, p1ii_q, p2rr_q, p2ii_q;
    logic signed [MW-1:0] prr_q, pii_q, pir_q, pri_q;

    // Stage 1: register the incoming samples
    always_ff @(posedge clk) begin
        x1_re_q <= din1_re;
        x1_im_q <= din1_im;
        x2_re_q <= din2_re;
        x2_im_q <= din2_im;
    end

    // Stage 2: all eight partial products
    always_ff @(posedge clk) begin
        p1rr_q <= x1_re_q * x1_re_q;
        p1ii_q <= x1_im_q * x1_im_q;
        p2rr_q <= x2_re_q * x2_re_q;
        p2ii_q <= x2_im_q * x2_im_q;
        prr_q  <= x1_re_q * x2_re_q;
        pii_q  <= x1_im_q * x2_im_q;
        pir_q  <= x1_im_q * x2_re_q;
        pri_q  <= x1_re_q * x2_im_q;
    end

    // Stage 3: |x1|^2, |x2|^2 and x1*conj(x2)
    always_ff @(posedge clk) begin
        r11    <= PW'(p1rr_q) + PW'(p1ii_q);
        r22    <= PW'(p2rr_q) + PW'(p2ii_q);
        r12_re <= PW'(prr_q) + PW'(pii_q);
        r12_im <= PW'(pir_q) - PW'(pri_q);
    end

endmodule

// File: rtl/v_uesprit_corr_acc.sv
// Per-bin 2x2 spatial correlation accumulator over a runtime number of frames.
module v_uesprit_corr_acc
    import uesprit_pkg::*;
#(
    parameter int unsigned DIN_WIDTH     = 18,
    parameter int unsigned DIN_POINT     = 17,
    parameter int unsigned VECTOR_LEN    = 512,
    parameter int unsigned ACC_LEN_WIDTH = 8,
    parameter int unsigned DOUT_WIDTH    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DIN_WIDTH-1:0]   din1_re,
    input  logic signed [DIN_WIDTH-1:0]   din1_im,
    input  logic signed [DIN_WIDTH-1:0]   din2_re,
    input  logic signed [DIN_WIDTH-1:0]   din2_im,
    input  logic                          din_valid,
    input  logic                          sync_in,
    input  logic [ACC_LEN_WIDTH-1:0]      acc_len,
    input  logic [4:0]                    shift,
    input  logic                          ovf_clr,
    output logic signed [DOUT_WIDTH-1:0]  r11,
    output logic signed [DOUT_WIDTH-1:0]  r22,
    output logic signed [DOUT_WIDTH-1:0]  r12_re,
    output logic signed [DOUT_WIDTH-1:0]  r12_im,
    output logic [$clog2(VECTOR_LEN)-1:0] dout_bin,
    output logic                          dout_valid,
    output logic                          ovf
);

    localparam int unsigned BW    = $clog2(VECTOR_LEN);
    localparam int unsigned AL    = ACC_LEN_WIDTH;
    localparam int unsigned PW    = calc_pw(DIN_WIDTH);
    localparam int unsigned ACC_W = calc_acc_w(DIN_WIDTH, ACC_LEN_WIDTH);

    if (VECTOR_LEN < 8 || (VECTOR_LEN & (VECTOR_LEN - 1)) != 0) begin : g_bad_len
        $error("VECTOR_LEN must be a power of two and at least 8");
    end
    if (DIN_POINT >= DIN_WIDTH) begin : g_bad_point
        $error("DIN_POINT must be below DIN_WIDTH");
    end
    if (ACC_W > SAT_W || DOUT_WIDTH > SAT_W) begin : g_bad_width
        $error("accumulator or output too wide for the saturation helper");
    end

    // acc_len==0 behaves as a single frame
    function automatic logic [AL-1:0] last_of(input logic [AL-1:0] n);
        return (n == '0) ? '0 : n - AL'(1);
    endfunction

    // ---------------- counters ----------------
    logic          armed_q;
    logic [BW-1:0] bin_q;
    logic [AL-1:0] frame_q, last_q;
    logic          go;
    logic [BW-1:0] cur_bin;
    logic [AL-1:0] cur_frame, cur_last;

    // Position of the current sample; a sync overrides the running counters
    always_comb begin
        go        = din_valid && (armed_q || sync_in);
        cur_bin   = sync_in ? '0 : bin_q;
        cur_frame = sync_in ? '0 : frame_q;
        cur_last  = sync_in ? last_of(acc_len) : last_q;
    end

    // Bin/frame counters and armed flag
    always_ff @(posedge clk) begin
        if (rst) begin
            armed_q <= 1'b0;
            bin_q   <= '0;
            frame_q <= '0;
            last_q  <= '0;
        end else if (go) begin
            armed_q <= 1'b1;
            bin_q   <= cur_bin + BW'(1);
            if (&cur_bin) begin
                frame_q <= (cur_frame == cur_last) ? '0 : cur_frame + AL'(1);
            end else begin
                frame_q <= cur_frame;
            end
            if (sync_in) begin
                last_q <= last_of(acc_len);
            end
        end
    end

    // ---------------- MAC ----------------
    logic signed [PW-1:0] mac_r11, mac_r22, mac_r12_re, mac_r12_im;

    uesprit_corr_mac #(
        .DIN_WIDTH (DIN_WIDTH),
        .PW        (PW)
    ) u_mac (
        .clk     (clk),
        .din1_re (din1_re),
        .din1_im (din1_im),
        .din2_re (din2_re),
        .din2_im (din2_im),
        .r11     (mac_r11),
        .r22     (mac_r22),
        .r12_re  (mac_r12_re),
        .r12_im  (mac_r12_im)
    );

    // ---------------- control pipeline ----------------
    logic          v0_q, v1_q, v2_q, v3_q, v4_q;
    logic          first0_q, first1_q, first2_q;
    logic          last0_q, last1_q, last2_q, last3_q;
    logic [BW-1:0] bin0_q, addr_q, bin2_q, bin3_q, bin4_q;

    // Valid bits track the sample through MAC, RAM read, add, shift and saturate
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
        end else begin
            v0_q <= go;
            v1_q <= v0_q;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q && last3_q;
        end
    end

    // Bin and frame-position tags travelling alongside the valid bits
    always_ff @(posedge clk) begin
        first0_q <= (cur_frame == '0);
        last0_q  <= (cur_frame == cur_last);
        bin0_q   <= cur_bin;
        first1_q <= first0_q;
        last1_q  <= last0_q;
        addr_q   <= bin0_q;
        first2_q <= first1_q;
        last2_q  <= last1_q;
        bin2_q   <= addr_q;
        last3_q  <= last2_q;
        bin3_q   <= bin2_q;
        bin4_q   <= bin3_q;
    end

    // ---------------- accumulator RAM ----------------
    logic [NC*ACC_W-1:0] mem [VECTOR_LEN];
    logic [NC*ACC_W-1:0] rd_q;
    logic [NC*ACC_W-1:0] wr_data;
    logic signed [ACC_W-1:0] sum_q [NC];

    always_comb begin
        wr_data = {sum_q[0], sum_q[1], sum_q[2], sum_q[3]};
    end

    // Write-back of the new sum; read address registered one cycle earlier
    always_ff @(posedge clk) begin
        if (v3_q) begin
            mem[bin3_q] <= wr_data;
        end
        rd_q <= mem[addr_q];
    end

    // ---------------- add ----------------
    logic signed [PW-1:0]    prod [NC];
    logic signed [ACC_W-1:0] prod_ext [NC];
    logic signed [ACC_W-1:0] old_val [NC];

    // Unpack the stored word and widen the fresh products
    always_comb begin
        prod[0] = mac_r11;
        prod[1] = mac_r22;
        prod[2] = mac_r12_re;
        prod[3] = mac_r12_im;
        for (int k = 0; k < NC; k++) begin
            prod_ext[k] = ACC_W'(prod[k]);
            old_val[k]  = $signed(rd_q[(NC - 1 - k) * ACC_W +: ACC_W]);
        end
    end

    // Frame 0 overwrites the stale word, so no clearing pass is needed
    always_ff @(posedge clk) begin
        for (int k = 0; k < NC; k++) begin
            sum_q[k] <= first2_q ? prod_ext[k] : old_val[k] + prod_ext[k];
        end
    end

    // ---------------- shift / saturate ----------------
    logic signed [ACC_W-1:0] sh_q [NC];
    logic signed [SAT_W-1:0] sat_val [NC];
    logic [NC-1:0]           sat_hit;

    // Arithmetic right shift, i.e. truncation toward -inf
    always_ff @(posedge clk) begin
        for (int k = 0; k < NC; k++) begin
            sh_q[k] <= sum_q[k] >>> shift;
        end
    end

    // Clamp each term to DOUT_WIDTH and flag any term that was clamped
    always_comb begin
        for (int k = 0; k < NC; k++) begin
            sat_val[k] = sat(SAT_W'(sh_q[k]), DOUT_WIDTH);
            sat_hit[k] = (sat_val[k] != SAT_W'(sh_q[k]));
        end
    end

    // Registered outputs hold between strobes; a new saturation beats ovf_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_bin   <= '0;
            r11        <= '0;
            r22        <= '0;
            r12_re     <= '0;
            r12_im     <= '0;
            ovf        <= 1'b0;
        end else begin
            dout_valid <= v4_q;
            if (v4_q) begin
                dout_bin <= bin4_q;
                r11      <= sat_val[0][DOUT_WIDTH-1:0];
                r22      <= sat_val[1][DOUT_WIDTH-1:0];
                r12_re   <= sat_val[2][DOUT_WIDTH-1:0];
                r12_im   <= sat_val[3][DOUT_WIDTH-1:0];
            end
            if (v4_q && (|sat_hit)) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_v_uesprit_corr_acc.sv
// Bench for v_uesprit_corr_acc: a 32-bit and a 16-bit output instance share stimulus.
module tb_v_uesprit_corr_acc;

    localparam int VL = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, din_valid, sync_in, ovf_clr;
    logic signed [17:0] d1r, d1i, d2r, d2i;
    logic [7:0]         acc_len;
    logic [4:0]         shift;

    logic signed [31:0] a_r11, a_r22, a_r12re, a_r12im;
    logic [2:0]         a_bin;
    logic               a_dv, a_ovf;
    logic signed [15:0] b_r11, b_r22, b_r12re, b_r12im;
    logic [2:0]         b_bin;
    logic               b_dv, b_ovf;

    v_uesprit_corr_acc #(
        .DIN_WIDTH(18), .DIN_POINT(17), .VECTOR_LEN(VL), .ACC_LEN_WIDTH(8), .DOUT_WIDTH(32)
    ) dut32 (
        .clk(clk), .rst(rst), .din1_re(d1r), .din1_im(d1i), .din2_re(d2r), .din2_im(d2i),
        .din_valid(din_valid), .sync_in(sync_in), .acc_len(acc_len), .shift(shift),
        .ovf_clr(ovf_clr), .r11(a_r11), .r22(a_r22), .r12_re(a_r12re), .r12_im(a_r12im),
        .dout_bin(a_bin), .dout_valid(a_dv), .ovf(a_ovf)
    );

    v_uesprit_corr_acc #(
        .DIN_WIDTH(18), .DIN_POINT(17), .VECTOR_LEN(VL), .ACC_LEN_WIDTH(8), .DOUT_WIDTH(16)
    ) dut16 (
        .clk(clk), .rst(rst), .din1_re(d1r), .din1_im(d1i), .din2_re(d2r), .din2_im(d2i),
        .din_valid(din_valid), .sync_in(sync_in), .acc_len(acc_len), .shift(shift),
        .ovf_clr(ovf_clr), .r11(b_r11), .r22(b_r22), .r12_re(b_r12re), .r12_im(b_r12im),
        .dout_bin(b_bin), .dout_valid(b_dv), .ovf(b_ovf)
    );

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int                       due;
        int                       bin;
        logic signed [3:0][63:0]  v32;
        logic signed [3:0][63:0]  v16;
        logic                     s32;
        logic                     s16;
    } exp_t;

    exp_t   q[$];
    longint acc[VL][4];
    bit     m_armed;
    int     m_bin, m_frame, m_last;
    longint e32[4], e16[4];
    int     ebin;
    bit     eovf32, eovf16;
    int     edge_n = 0;
    bit     clr_at_edge = 1'b0;
    bit     checking = 1'b0;
    int     dut_strobes = 0;

    function automatic longint satw(input longint v, input int w);
        longint mx, mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        return (v > mx) ? mx : ((v < mn) ? mn : v);
    endfunction

    // Accept one valid sample into the model; sampled by the DUT at edge edge_n+1
    task automatic model_sample(input bit s, input int x1r, input int x1i,
                                input int x2r, input int x2i);
        longint p[4];
        exp_t   e;
        if (s) begin
            m_bin = 0;
            m_frame = 0;
            m_last = (acc_len == 0) ? 0 : int'(acc_len) - 1;
            m_armed = 1'b1;
        end
        if (!m_armed) return;
        p[0] = longint'(x1r) * x1r + longint'(x1i) * x1i;
        p[1] = longint'(x2r) * x2r + longint'(x2i) * x2i;
        p[2] = longint'(x1r) * x2r + longint'(x1i) * x2i;
        p[3] = longint'(x1i) * x2r - longint'(x1r) * x2i;
        for (int k = 0; k < 4; k++) begin
            acc[m_bin][k] = (m_frame == 0) ? p[k] : acc[m_bin][k] + p[k];
        end
        if (m_frame == m_last) begin
            e.due = edge_n + 6;
            e.bin = m_bin;
            e.s32 = 1'b0;
            e.s16 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                longint sv;
                sv = acc[m_bin][k] >>> shift;
                e.v32[k] = satw(sv, 32);
                e.v16[k] = satw(sv, 16);
                if (satw(sv, 32) != sv) e.s32 = 1'b1;
                if (satw(sv, 16) != sv) e.s16 = 1'b1;
            end
            q.push_back(e);
        end
        if (m_bin == VL - 1) begin
            m_bin = 0;
            m_frame = (m_frame == m_last) ? 0 : m_frame + 1;
        end else begin
            m_bin++;
        end
    endtask

    always @(posedge clk) begin
        edge_n      <= edge_n + 1;
        clr_at_edge <= ovf_clr;
    end

    // Compare both instances against the model after every clock edge
    always @(negedge clk) begin
        if (checking) begin
            bit   st;
            exp_t e;
            st = 1'b0;
            e = '0;
            if (q.size() > 0 && q[0].due <= edge_n) begin
                e = q.pop_front();
                st = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    e32[k] = e.v32[k];
                    e16[k] = e.v16[k];
                end
                ebin = e.bin;
            end
            if (st && e.s32) eovf32 = 1'b1;
            else if (clr_at_edge) eovf32 = 1'b0;
            if (st && e.s16) eovf16 = 1'b1;
            else if (clr_at_edge) eovf16 = 1'b0;
            if (a_dv) dut_strobes++;
            chk("dv32", a_dv, st);
            chk("bin32", a_bin, ebin);
            chk("r11_32", a_r11, e32[0]);
            chk("r22_32", a_r22, e32[1]);
            chk("r12re_32", a_r12re, e32[2]);
            chk("r12im_32", a_r12im, e32[3]);
            chk("ovf32", a_ovf, eovf32);
            chk("dv16", b_dv, st);
            chk("bin16", b_bin, ebin);
            chk("r11_16", b_r11, e16[0]);
            chk("r22_16", b_r22, e16[1]);
            chk("r12re_16", b_r12re, e16[2]);
            chk("r12im_16", b_r12im, e16[3]);
            chk("ovf16", b_ovf, eovf16);
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input bit v, input bit s, input int x1r, input int x1i,
                       input int x2r, input int x2i);
        d1r = 18'(x1r);
        d1i = 18'(x1i);
        d2r = 18'(x2r);
        d2i = 18'(x2i);
        din_valid = v;
        sync_in = s;
        if (v) model_sample(s, x1r, x1i, x2r, x2i);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 7, -7, 5, -5);
    endtask

    // mode 0: fixed (3,4)/(1,2); mode 1: per-bin data; mode 2: saturating x1
    task automatic run_bins(input int nb, input bit sync_first, input int mode, input bit gaps);
        for (int i = 0; i < nb; i++) begin
            int b;
            b = i % VL;
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) put(1'b0, 1'b0, 9, 9, 9, 9);
            end
            case (mode)
                0:       put(1'b1, sync_first && i == 0, 3, 4, 1, 2);
                1:       put(1'b1, sync_first && i == 0, b + 1, 2, 1, -b);
                default: put(1'b1, sync_first && i == 0, -131072, -131072, 0, 0);
            endcase
        end
    endtask

    task automatic do_reset();
        checking = 1'b0;
        rst = 1'b1;
        din_valid = 1'b0;
        sync_in = 1'b0;
        ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
        m_armed = 1'b0;
        m_bin = 0;
        m_frame = 0;
        for (int k = 0; k < 4; k++) begin
            e32[k] = 0;
            e16[k] = 0;
        end
        ebin = 0;
        eovf32 = 1'b0;
        eovf16 = 1'b0;
        checking = 1'b1;
    endtask

    initial begin
        int s0;
        rst = 1'b1;
        din_valid = 1'b0;
        sync_in = 1'b0;
        ovf_clr = 1'b0;
        acc_len = 8'd4;
        shift = 5'd0;
        d1r = '0; d1i = '0; d2r = '0; d2i = '0;
        @(negedge clk);
        do_reset();

        // reset state
        chk("reset_r11", a_r11, 0);
        chk("reset_dv", a_dv, 0);
        chk("reset_ovf", b_ovf, 0);

        // 1: no sync, three frames of data -> no output
        s0 = dut_strobes;
        run_bins(3 * VL, 1'b0, 0, 1'b0);
        idle(10);
        chk("t1_strobes", dut_strobes - s0, 0);

        // 2: acc_len=4, shift=0, eight frames -> two windows of 8 strobes
        s0 = dut_strobes;
        run_bins(8 * VL, 1'b1, 0, 1'b0);
        idle(10);
        chk("t2_strobes", dut_strobes - s0, 16);
        chk("t2_r11", a_r11, 100);
        chk("t2_r22", a_r22, 20);
        chk("t2_r12re", a_r12re, 44);
        chk("t2_r12im", a_r12im, -8);
        chk("t2_bin", a_bin, 7);

        // 3: shift=2 with random gaps
        shift = 5'd2;
        s0 = dut_strobes;
        run_bins(4 * VL, 1'b1, 0, 1'b1);
        idle(10);
        chk("t3_strobes", dut_strobes - s0, 8);
        chk("t3_r11", a_r11, 25);
        chk("t3_r22", b_r22, 5);
        chk("t3_r12re", a_r12re, 11);
        chk("t3_r12im", b_r12im, -2);

        // 4: acc_len=0 -> one output per frame
        shift = 5'd0;
        acc_len = 8'd0;
        s0 = dut_strobes;
        run_bins(2 * VL, 1'b1, 0, 1'b0);
        idle(10);
        chk("t4_strobes", dut_strobes - s0, 16);
        chk("t4_r11", a_r11, 25);
        chk("t4_r12im", a_r12im, -2);

        // 5: saturation, sticky ovf, clear, set-beats-clear
        acc_len = 8'd1;
        run_bins(VL, 1'b1, 2, 1'b0);
        idle(10);
        chk("t5_r11_16", b_r11, 32767);
        chk("t5_r11_32", a_r11, 64'sd2147483647);
        chk("t5_ovf16", b_ovf, 1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        idle(2);
        chk("t5_ovf_clr", b_ovf, 0);
        run_bins(VL, 1'b0, 0, 1'b0);
        idle(10);
        chk("t5_benign_ovf", b_ovf, 0);
        chk("t5_benign_r11", b_r11, 25);
        ovf_clr = 1'b1;
        run_bins(VL, 1'b0, 2, 1'b0);
        idle(10);
        ovf_clr = 1'b0;
        idle(2);

        // 6: sync restart at bin 3 of frame 2
        acc_len = 8'd4;
        s0 = dut_strobes;
        run_bins(2 * VL + 3, 1'b1, 1, 1'b0);
        run_bins(4 * VL, 1'b1, 1, 1'b0);
        idle(10);
        chk("t6_strobes", dut_strobes - s0, 8);
        chk("t6_r11", a_r11, 272);
        chk("t6_r22", a_r22, 200);
        chk("t6_r12re", a_r12re, -24);
        chk("t6_r12im", a_r12im, 232);

        // rst mid-accumulation, then unsynced data -> no output
        run_bins(2 * VL, 1'b1, 0, 1'b0);
        do_reset();
        s0 = dut_strobes;
        run_bins(3 * VL, 1'b0, 0, 1'b0);
        idle(10);
        chk("t6_rst_strobes", dut_strobes - s0, 0);
        run_bins(4 * VL, 1'b1, 0, 1'b0);
        idle(10);
        chk("t6_resync_strobes", dut_strobes - s0, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
